// File: rtl/uart_tx_mmio_pkg.sv
// Shared bus and UART definitions for the MMIO transmitter.
// Response codes and FSM encoding live here for reuse by an RX path.
package uart_tx_mmio_pkg;

  localparam int BUS_WIDTH      = 32;
  localparam int BUS_RESP_WIDTH = 1;
  localparam int DIV_WIDTH      = 16;

  localparam logic [BUS_RESP_WIDTH-1:0] RESP_OKAY  = 1'b0;
  localparam logic [BUS_RESP_WIDTH-1:0] RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// Pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: TXDATA/DIV registers, TX FIFO, 8N1 serialiser.
// tx is registered from the FSM state, so the line trails the state by one clock.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [BUS_WIDTH-1:0] ADDR_TXDATA = 32'h8004,
  parameter logic [BUS_WIDTH-1:0] ADDR_DIV    = 32'h8008,
  parameter int                   DEFAULT_DIV = 16,
  parameter int                   FIFO_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dw_data_addr_valid,
  output logic                      dw_data_addr_ready,
  input  logic [BUS_WIDTH-1:0]      dw_addr,
  input  logic [BUS_WIDTH-1:0]      dw_data,
  input  logic [BUS_WIDTH/8-1:0]    dw_strobe,
  output logic                      dw_resp_valid,
  input  logic                      dw_resp_ready,
  output logic [BUS_RESP_WIDTH-1:0] dw_resp,
  output logic                      tx,
  output logic                      busy
);

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

  logic                      accept, is_tx, is_div;
  logic                      push, pop, full, empty;
  logic [7:0]                head;
  logic                      pend_q, pend_d;
  logic [BUS_RESP_WIDTH-1:0] resp_q, resp_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  uart_state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0]      baud_q, baud_d;
  logic [DIV_WIDTH-1:0]      fdiv_q, fdiv_d;
  logic [2:0]                bit_q, bit_d;
  logic [7:0]                shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      baud_last;
  logic                      unused_bits;

  assign unused_bits = ^{dw_data[BUS_WIDTH-1:DIV_WIDTH],
                         dw_strobe[BUS_WIDTH/8-1:1]};

  assign dw_data_addr_ready = !rst && !pend_q && !full;
  assign accept        = dw_data_addr_valid && dw_data_addr_ready;
  assign is_tx         = dw_addr == ADDR_TXDATA;
  assign is_div        = dw_addr == ADDR_DIV;
  assign push          = accept && is_tx && dw_strobe[0];
  assign dw_resp_valid = pend_q;
  assign dw_resp       = resp_q;
  assign tx            = tx_q;
  assign busy          = !empty || (state_q != S_IDLE);
  assign baud_last     = baud_q == (fdiv_q - DIV_ONE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (dw_data[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pend_d = pend_q;
    resp_d = resp_q;
    div_d  = div_q;
    if (pend_q && dw_resp_ready) pend_d = 1'b0;
    if (accept) begin
      pend_d = 1'b1;
      resp_d = (is_tx || is_div) ? RESP_OKAY : RESP_ERROR;
      if (is_div) begin
        div_d = (dw_data[DIV_WIDTH-1:0] == '0) ? DIV_ONE
                                               : dw_data[DIV_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    fdiv_d  = fdiv_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + DIV_ONE;
    end
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          fdiv_d  = div_q;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          // back-to-back frames: reload straight into START
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            fdiv_d  = div_q;
            baud_d  = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
      div_q   <= DIV_RST;
      state_q <= S_IDLE;
      baud_q  <= '0;
      fdiv_q  <= DIV_RST;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      pend_q  <= pend_d;
      resp_q  <= resp_d;
      div_q   <= div_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      fdiv_q  <= fdiv_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register writes, frame timing,
// FIFO backpressure, response hold and mid-frame reset.
module tb_uart_tx_mmio;
  import uart_tx_mmio_pkg::*;

  localparam logic [31:0] A_TX  = 32'h8004;
  localparam logic [31:0] A_DIV = 32'h8008;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dw_data_addr_valid = 1'b0;
  logic        dw_data_addr_ready;
  logic [31:0] dw_addr = '0;
  logic [31:0] dw_data = '0;
  logic [3:0]  dw_strobe = '0;
  logic        dw_resp_valid;
  logic        dw_resp_ready = 1'b1;
  logic [0:0]  dw_resp;
  logic        tx;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  logic tx_hist [HN];
  logic busy_hist [HN];

  uart_tx_mmio dut (
    .clk                (clk),
    .rst                (rst),
    .dw_data_addr_valid (dw_data_addr_valid),
    .dw_data_addr_ready (dw_data_addr_ready),
    .dw_addr            (dw_addr),
    .dw_data            (dw_data),
    .dw_strobe          (dw_strobe),
    .dw_resp_valid      (dw_resp_valid),
    .dw_resp_ready      (dw_resp_ready),
    .dw_resp            (dw_resp),
    .tx                 (tx),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HN) begin
      tx_hist[cyc]   = tx;
      busy_hist[cyc] = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int e);
    int n = 0;
    dw_data_addr_valid = 1'b1;
    dw_addr   = a;
    dw_data   = d;
    dw_strobe = s;
    while (!dw_data_addr_ready && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      $error("FAIL send_timeout: observed ready 0 expected 1");
    end
    tick(1);
    e = cyc;
    dw_data_addr_valid = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    input logic exp_err, output int e);
    int n = 0;
    send(a, d, s, e);
    while (!dw_resp_valid && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, {dw_resp_valid, 30'd0, dw_resp}, {1'b1, 30'd0, exp_err});
    tick(1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
    tick(2);
  endtask

  task automatic check_frame(input string tag, input int s,
                             input logic [7:0] b, input int div);
    int errs = 0;
    for (int i = 0; i < 10 * div; i++) begin
      int k;
      logic e;
      k = i / div;
      if (k == 0) e = 1'b0;
      else if (k == 9) e = 1'b1;
      else e = b[k-1];
      if (tx_hist[s+i] !== e) errs++;
    end
    if (tx_hist[s-1] !== 1'b1) errs++;
    chk(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    int e, e1, e2, e3, r0, errs, t0;
    int acc [10];

    tick(2);
    chk("rst_ready", 32'(dw_data_addr_ready), 32'd0);
    chk("rst_resp_valid", 32'(dw_resp_valid), 32'd0);
    chk("rst_resp", 32'(dw_resp), 32'(RESP_OKAY));
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", 32'(dw_data_addr_ready), 32'd1);

    // div=4, byte 0x41
    wr("div4_resp", A_DIV, 32'd4, 4'hF, 1'b0, e);
    wr("tx41_resp", A_TX, 32'h41, 4'h1, 1'b0, e);
    wait_idle("t1_idle", 200);
    check_frame("t1_frame", e + 2, 8'h41, 4);
    chk("t1_busy_last", 32'(busy_hist[e+40]), 32'd1);
    chk("t1_busy_end", 32'(busy_hist[e+41]), 32'd0);
    chk("t1_tx_after", 32'(tx_hist[e+42]), 32'd1);

    // error address and strobe-less write
    wr("err_resp", 32'h8010, 32'hFF, 4'hF, 1'b1, e);
    wr("nostrb_resp", A_TX, 32'h5A, 4'hE, 1'b0, e1);
    tick(4);
    errs = 0;
    for (int i = e; i < cyc; i++) begin
      if (busy_hist[i] !== 1'b0 || tx_hist[i] !== 1'b1) errs++;
    end
    chk("err_noside", 32'(errs), 32'd0);

    // response held for 5 cycles, second request pending
    dw_resp_ready = 1'b0;
    send(A_DIV, 32'd16, 4'hF, e);
    dw_data_addr_valid = 1'b1;
    dw_addr   = A_TX;
    dw_data   = 32'h77;
    dw_strobe = 4'h1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (dw_resp_valid !== 1'b1) errs++;
      if (dw_resp !== RESP_OKAY) errs++;
      if (dw_data_addr_ready !== 1'b0) errs++;
      tick(1);
    end
    chk("hold_stable", 32'(errs), 32'd0);
    dw_data_addr_valid = 1'b0;
    dw_resp_ready = 1'b1;
    tick(1);
    chk("hold_valid_drop", 32'(dw_resp_valid), 32'd0);
    chk("hold_ready_back", 32'(dw_data_addr_ready), 32'd1);
    chk("hold_no_push", 32'(busy), 32'd0);

    // 10 back-to-back bytes at div=16
    for (int i = 0; i < 10; i++) begin
      wr("b2b_resp", A_TX, 32'h10 + i, 4'h1, 1'b0, acc[i]);
    end
    chk("b2b_9th_accept", 32'(acc[8] - acc[0]), 32'd16);
    chk("b2b_10th_accept", 32'(acc[9] - acc[0]), 32'd162);
    wait_idle("b2b_idle", 2000);
    for (int k = 0; k < 10; k++) begin
      check_frame("b2b_frame", acc[0] + 2 + 160 * k, 8'(8'h10 + k), 16);
    end
    chk("b2b_busy_end", 32'(busy_hist[acc[0]+1601]), 32'd0);

    // div=0 -> 1, then div=8 mid-frame
    wr("div0_resp", A_DIV, 32'd0, 4'hF, 1'b0, e);
    wr("tx55_resp", A_TX, 32'h55, 4'h1, 1'b0, e1);
    wr("div8_resp", A_DIV, 32'd8, 4'h0, 1'b0, e2);
    wr("txc3_resp", A_TX, 32'hC3, 4'h1, 1'b0, e3);
    chk("div8_in_frame", 32'(e2 > e1 + 1 && e2 < e1 + 11), 32'd1);
    wait_idle("div_idle", 300);
    check_frame("div1_frame", e1 + 2, 8'h55, 1);
    check_frame("div8_frame", e1 + 12, 8'hC3, 8);
    chk("div8_busy_last", 32'(busy_hist[e1+90]), 32'd1);
    chk("div8_busy_end", 32'(busy_hist[e1+91]), 32'd0);

    // reset during data bit 3 with 3 bytes queued (div=8)
    wr("q0_resp", A_TX, 32'h11, 4'h1, 1'b0, r0);
    wr("q1_resp", A_TX, 32'h22, 4'h1, 1'b0, e);
    wr("q2_resp", A_TX, 32'h33, 4'h1, 1'b0, e);
    wr("q3_resp", A_TX, 32'h44, 4'h1, 1'b0, e);
    tick(r0 + 34 - cyc);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #0;
    chk("rst_cycle_ready", 32'(dw_data_addr_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    t0 = cyc;
    tick(200);
    errs = 0;
    for (int i = t0; i < cyc; i++) begin
      if (tx_hist[i] !== 1'b1 || busy_hist[i] !== 1'b0) errs++;
    end
    chk("rst_quiet", 32'(errs), 32'd0);
    wr("post_rst_resp", A_TX, 32'hA5, 4'h1, 1'b0, e);
    wait_idle("post_rst_idle", 400);
    check_frame("post_rst_frame", e + 2, 8'hA5, 16);
    chk("post_rst_busy_last", 32'(busy_hist[e+160]), 32'd1);
    chk("post_rst_busy_end", 32'(busy_hist[e+161]), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
